cross_product_arbiter: RTL and testbench
========================================

Name: cross_product_arbiter

Overview:
Round-robin arbiter that shares one vector cross-product unit among `num_requesters` plane-fitting lanes in the RANSAC pipeline. It accepts one request at a time, issues that request's operands to the cross-product unit, and waits for the result. It then returns the result to the granted lane with a valid/ready handshake. It also keeps a completed-operation counter for performance monitoring.

Parameters:
num_requesters, 4, number of requesting lanes; legal range 2..16.
id_width, $clog2(num_requesters), width of the grant/response ID.

Ports:
clock  in  1  single clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  num_requesters  per-lane request valid.
req_lhs  in  num_requesters x vector3f_t  per-lane left operand.
req_rhs  in  num_requesters x vector3f_t  per-lane right operand.
req_ready  out  num_requesters  one-hot; high for exactly one cycle when that lane's request is accepted.
resp_valid  out  num_requesters  one-hot; result valid for the granted lane.
resp_ready  in  num_requesters  per-lane response accept.
resp_id  out  id_width  ID of the lane being answered.
resp_res  out  vector3f_t  cross product lhs x rhs.
cp_input_valid  out  1  request to the cross-product unit.
cp_lhs  out  vector3f_t  left operand to the unit.
cp_rhs  out  vector3f_t  right operand to the unit.
cp_input_ready  in  1  unit idle/ready.
cp_output_valid  in  1  unit result valid.
cp_res  in  vector3f_t  unit result.
ops_completed  out  32  count of completed responses; wraps 2^32-1 -> 0.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE.
  - req_ready=0, resp_valid=0, cp_input_valid=0, resp_id=0, resp_res=0, cp_lhs=cp_rhs=0, ops_completed=0.
  - last_grant=num_requesters-1, so lane 0 has first priority.
- Unit protocol: the unit holds cp_output_valid high while idle. cp_output_valid therefore counts as a result only after the unit has dropped cp_input_ready following an issue.
- IDLE:
  - If any req_valid, choose the first set lane scanning last_grant+1, last_grant+2, ... modulo num_requesters.
  - Latch that lane's operands into cp_lhs/cp_rhs and the lane ID into grant_id.
  - Pulse req_ready[grant_id]=1 for one cycle; go to ISSUE.
  - Otherwise remain in IDLE with all handshake outputs low.
- ISSUE:
  - Hold cp_input_valid=1 with operands stable.
  - When cp_input_ready is sampled 0 (unit has accepted), drop cp_input_valid and go to WAIT_RESULT.
- WAIT_RESULT:
  - When cp_output_valid=1 and cp_input_ready=1, latch cp_res into resp_res, set resp_id=grant_id, set resp_valid[grant_id]=1, and go to RESPOND.
- RESPOND:
  - Hold resp_valid, resp_id and resp_res stable until resp_ready[grant_id]=1.
  - In that cycle: resp_valid becomes 0 next cycle, last_grant=grant_id, ops_completed increments, state returns to IDLE.
  - resp_ready on non-granted lanes is ignored.
- Latency: request accept to resp_valid equals unit latency + 3 cycles (IDLE->ISSUE, accept detect, result latch). Minimum spacing between req_ready pulses is unit latency + 4 cycles.
- Fairness: a lane that holds req_valid waits at most num_requesters-1 other grants.
- Requests from other lanes arriving while busy are not accepted; their req_ready stays 0 and lanes must hold req_valid.
- Lane dropping req_valid:
  - If it drops before its grant, it is simply skipped.
  - If it drops after its req_ready pulse, the operation completes normally.
- Simultaneous requests in the same cycle: only round-robin order decides.
- Reset mid-operation: all state clears immediately and no response is produced. The cross-product unit shares the same reset.
- Arithmetic is performed entirely by the unit; this block does not alter values.

Test Plan:
- Single request: lane 2 sends lhs=(1,0,0), rhs=(0,1,0) in fixed point -> req_ready[2] pulses once, cp_input_valid asserts next cycle, resp_valid[2] with resp_res=(0,0,1), resp_id=2, ops_completed=1 after handshake.
- All four lanes request at once from reset, each lane n with lhs=(0,0,1), rhs=(n,0,0) -> grants in order 0,1,2,3, each resp_res=(0,n,0), ops_completed=4.
- Fairness: lanes 0 and 1 continuously valid for 6 operations -> grants alternate 0,1,0,1,0,1; no lane is served twice in a row.
- Backpressure: hold resp_ready[1]=0 for 10 cycles after resp_valid[1] rises -> resp_res and resp_id stay stable, no new req_ready pulses, completion on the first cycle resp_ready[1]=1.
- Idle-valid filter: unit idles with cp_output_valid=1 before the issue -> block does not produce a response until after cp_input_ready has fallen and risen again; result matches (2,3,4)x(5,6,7)=(-3,6,-3).
- Reset during WAIT_RESULT: assert reset asynchronously mid-operation -> all outputs 0 in the same cycle, no resp_valid afterwards; next request (lane 0) proceeds normally.

Source files
------------

// File: rtl/cross_product_arbiter_if.sv
// Shared vector type and the lane/unit handshake bus for the cross-product arbiter.
// Each vector component is a signed Q16.16 fixed-point value.
package cross_product_arbiter_pkg;
  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] z;
  } vector3f_t;
endpackage

interface cross_product_arbiter_if
  import cross_product_arbiter_pkg::*;
#(
  parameter int num_requesters = 4,
  parameter int id_width       = $clog2(num_requesters)
);
  logic      [num_requesters-1:0] req_valid;
  vector3f_t [num_requesters-1:0] req_lhs;
  vector3f_t [num_requesters-1:0] req_rhs;
  logic      [num_requesters-1:0] req_ready;
  logic      [num_requesters-1:0] resp_valid;
  logic      [num_requesters-1:0] resp_ready;
  logic      [id_width-1:0]       resp_id;
  vector3f_t                      resp_res;
  logic                           cp_input_valid;
  vector3f_t                      cp_lhs;
  vector3f_t                      cp_rhs;
  logic                           cp_input_ready;
  logic                           cp_output_valid;
  vector3f_t                      cp_res;

  // Lanes plus the cross-product unit: everything outside the arbiter.
  modport master (
    output req_valid, req_lhs, req_rhs, resp_ready,
           cp_input_ready, cp_output_valid, cp_res,
    input  req_ready, resp_valid, resp_id, resp_res,
           cp_input_valid, cp_lhs, cp_rhs
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_lhs, req_rhs, resp_ready,
           cp_input_ready, cp_output_valid, cp_res,
    output req_ready, resp_valid, resp_id, resp_res,
           cp_input_valid, cp_lhs, cp_rhs
  );
endinterface

// File: rtl/cross_product_arbiter.sv
// Round-robin arbiter sharing one cross-product unit among the plane-fitting lanes.
// One operation is in flight at a time: accept, issue to the unit, wait, respond.
module cross_product_arbiter
  import cross_product_arbiter_pkg::*;
#(
  parameter int num_requesters = 4,
  parameter int id_width       = $clog2(num_requesters)
) (
  input  logic                         clock,
  input  logic                         reset,
  cross_product_arbiter_if.slave       bus,
  output logic [31:0]                  ops_completed
);

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_ISSUE       = 2'd1;
  localparam logic [1:0] ST_WAIT_RESULT = 2'd2;
  localparam logic [1:0] ST_RESPOND     = 2'd3;

  localparam logic [id_width-1:0] last_lane = id_width'(num_requesters - 1);
  localparam logic [id_width:0]   lane_count = (id_width + 1)'(num_requesters);

  logic [1:0]                state;
  logic [id_width-1:0]       last_grant;
  logic [id_width-1:0]       grant_id;
  logic [id_width-1:0]       pick_id;
  logic                      pick_found;
  logic [id_width:0]         rr_sum;
  logic [id_width-1:0]       rr_idx;
  logic [num_requesters-1:0] grant_onehot;
  logic                      resp_accept;

  logic                      cp_input_valid_q;
  vector3f_t                 cp_lhs_q;
  vector3f_t                 cp_rhs_q;
  logic [num_requesters-1:0] resp_valid_q;
  logic [id_width-1:0]       resp_id_q;
  vector3f_t                 resp_res_q;

  // Scan lanes starting just after the last served one and take the first valid.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    rr_sum     = '0;
    rr_idx     = '0;
    for (int k = 1; k <= num_requesters; k++) begin
      rr_sum = {1'b0, last_grant} + (id_width + 1)'(k);
      if (rr_sum >= lane_count) begin
        rr_sum = rr_sum - lane_count;
      end
      rr_idx = rr_sum[id_width-1:0];
      if (!pick_found && bus.req_valid[rr_idx]) begin
        pick_found = 1'b1;
        pick_id    = rr_idx;
      end
    end
  end

  // Accept pulse is combinational so it coincides with the cycle the operands are captured.
  always_comb begin
    grant_onehot = '0;
    if (state == ST_IDLE && pick_found && !reset) begin
      grant_onehot[pick_id] = 1'b1;
    end
  end

  assign resp_accept = (state == ST_RESPOND) && bus.resp_ready[grant_id];

  // Main sequencer; cp_output_valid is only trusted after the unit has dropped ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      last_grant       <= last_lane;
      grant_id         <= '0;
      cp_input_valid_q <= 1'b0;
      cp_lhs_q         <= '0;
      cp_rhs_q         <= '0;
      resp_valid_q     <= '0;
      resp_id_q        <= '0;
      resp_res_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id         <= pick_id;
            cp_lhs_q         <= bus.req_lhs[pick_id];
            cp_rhs_q         <= bus.req_rhs[pick_id];
            cp_input_valid_q <= 1'b1;
            state            <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!bus.cp_input_ready) begin
            cp_input_valid_q <= 1'b0;
            state            <= ST_WAIT_RESULT;
          end
        end
        ST_WAIT_RESULT: begin
          if (bus.cp_output_valid && bus.cp_input_ready) begin
            resp_res_q   <= bus.cp_res;
            resp_id_q    <= grant_id;
            resp_valid_q <= num_requesters'(1) << grant_id;
            state        <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (resp_accept) begin
            resp_valid_q <= '0;
            last_grant   <= grant_id;
            state        <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Completed-operation counter, wraps naturally at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ops_completed <= '0;
    end else if (resp_accept) begin
      ops_completed <= ops_completed + 32'd1;
    end
  end

  assign bus.req_ready      = grant_onehot;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_id        = resp_id_q;
  assign bus.resp_res       = resp_res_q;
  assign bus.cp_input_valid = cp_input_valid_q;
  assign bus.cp_lhs         = cp_lhs_q;
  assign bus.cp_rhs         = cp_rhs_q;

endmodule

// File: tb/tb_cross_product_arbiter.sv
// Self-checking bench for cross_product_arbiter with a behavioural cross-product unit,
// a round-robin reference model and a result scoreboard.
module tb_cross_product_arbiter;
  import cross_product_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 3;

  typedef struct {
    int        lane;
    vector3f_t res;
  } sb_entry_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ops_completed;

  cross_product_arbiter_if #(.num_requesters(N)) bus ();

  cross_product_arbiter #(.num_requesters(N)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus.slave),
    .ops_completed (ops_completed)
  );

  always #5 clock = ~clock;

  int        total = 0;
  int        bad = 0;
  sb_entry_t sb_q[$];
  int        grant_log[$];
  vector3f_t lane_exp [N];
  int        lane_left [N];
  logic      drop_pending [N];
  logic      busy;
  int        model_last;
  int        exp_ops;

  function automatic vector3f_t vec(input int x, input int y, input int z);
    vector3f_t v;
    v.x = x * 65536;
    v.y = y * 65536;
    v.z = z * 65536;
    return v;
  endfunction

  function automatic vector3f_t cross_fx(input vector3f_t a, input vector3f_t b);
    vector3f_t r;
    longint t;
    t = (longint'(a.y) * longint'(b.z) - longint'(a.z) * longint'(b.y)) >>> 16;
    r.x = 32'(t);
    t = (longint'(a.z) * longint'(b.x) - longint'(a.x) * longint'(b.z)) >>> 16;
    r.y = 32'(t);
    t = (longint'(a.x) * longint'(b.y) - longint'(a.y) * longint'(b.x)) >>> 16;
    r.z = 32'(t);
    return r;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Behavioural unit: idles with ready and a stale valid high, goes busy for LAT cycles on issue.
  logic      u_busy;
  int        u_cnt;
  vector3f_t u_res;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      u_busy              <= 1'b0;
      u_cnt               <= 0;
      u_res               <= '0;
      bus.cp_input_ready  <= 1'b1;
      bus.cp_output_valid <= 1'b1;
      bus.cp_res          <= vec(9, 9, 9);
    end else if (!u_busy) begin
      if (bus.cp_input_valid && bus.cp_input_ready) begin
        u_res               <= cross_fx(bus.cp_lhs, bus.cp_rhs);
        u_busy              <= 1'b1;
        u_cnt               <= LAT - 1;
        bus.cp_input_ready  <= 1'b0;
        bus.cp_output_valid <= 1'b0;
      end
    end else if (u_cnt == 0) begin
      u_busy              <= 1'b0;
      bus.cp_res          <= u_res;
      bus.cp_input_ready  <= 1'b1;
      bus.cp_output_valid <= 1'b1;
    end else begin
      u_cnt <= u_cnt - 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int lane, input vector3f_t lhs, input vector3f_t rhs,
                               input vector3f_t exp_res, input int reps);
    bus.req_lhs[lane]   = lhs;
    bus.req_rhs[lane]   = rhs;
    lane_exp[lane]      = exp_res;
    lane_left[lane]     = reps;
    bus.req_valid[lane] = 1'b1;
  endtask

  // One clock: check accept and response at the falling edge, release lanes just after the rising edge.
  task automatic step();
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_v;
    int           pick;
    sb_entry_t    e;
    @(negedge clock);
    exp_ready = '0;
    pick      = -1;
    if (!busy) begin
      pick = rr_pick(bus.req_valid, model_last);
      if (pick >= 0) exp_ready[pick] = 1'b1;
    end
    checkOutput("req_ready", bus.req_ready, exp_ready);
    if (pick >= 0) begin
      sb_q.push_back('{lane: pick, res: lane_exp[pick]});
      grant_log.push_back(pick);
      busy = 1'b1;
      lane_left[pick]--;
      if (lane_left[pick] <= 0) drop_pending[pick] = 1'b1;
    end
    if ((bus.resp_valid & bus.resp_ready) != '0) begin
      if (sb_q.size() == 0) begin
        checkOutput("resp_unexpected", bus.resp_valid, 0);
      end else begin
        e     = sb_q.pop_front();
        exp_v = '0;
        exp_v[e.lane] = 1'b1;
        checkOutput("resp_valid", bus.resp_valid, exp_v);
        checkOutput("resp_id", bus.resp_id, e.lane);
        checkOutput("resp_res", bus.resp_res, e.res);
        checkOutput("ops_before", ops_completed, exp_ops);
        exp_ops++;
        busy       = 1'b0;
        model_last = e.lane;
      end
    end else if (!busy) begin
      checkOutput("resp_idle", bus.resp_valid, 0);
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      if (drop_pending[i]) begin
        bus.req_valid[i] = 1'b0;
        drop_pending[i]  = 1'b0;
      end
    end
  endtask

  task automatic run_until_quiet(input int budget);
    int n;
    n = 0;
    while ((busy || bus.req_valid != '0) && n < budget) begin
      step();
      n++;
    end
    if (busy || bus.req_valid != '0) begin
      checkOutput("timeout_quiet", 1, 0);
      bus.req_valid = '0;
      busy = 1'b0;
      sb_q.delete();
    end
  endtask

  task automatic check_grants(input int exp_seq[$]);
    checkOutput("grant_count", grant_log.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < grant_log.size(); i++) begin
      checkOutput("grant_order", grant_log[i], exp_seq[i]);
    end
  endtask

  // Asynchronous reset at the current time, checked before the next edge, released after two clocks.
  task automatic do_reset();
    reset          = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = '1;
    for (int i = 0; i < N; i++) begin
      bus.req_lhs[i]  = '0;
      bus.req_rhs[i]  = '0;
      lane_exp[i]     = '0;
      lane_left[i]    = 0;
      drop_pending[i] = 1'b0;
    end
    busy       = 1'b0;
    model_last = N - 1;
    exp_ops    = 0;
    sb_q.delete();
    grant_log.delete();
    #1;
    checkOutput("rst_req_ready", bus.req_ready, 0);
    checkOutput("rst_resp_valid", bus.resp_valid, 0);
    checkOutput("rst_cp_valid", bus.cp_input_valid, 0);
    checkOutput("rst_resp_id", bus.resp_id, 0);
    checkOutput("rst_resp_res", bus.resp_res, 0);
    checkOutput("rst_cp_lhs", bus.cp_lhs, 0);
    checkOutput("rst_cp_rhs", bus.cp_rhs, 0);
    checkOutput("rst_ops", ops_completed, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int        n;
    logic      saw_fall;
    vector3f_t exp_bp;
    #1;
    do_reset();

    // Single request from lane 2.
    applyStimulus(2, vec(1, 0, 0), vec(0, 1, 0), vec(0, 0, 1), 1);
    step();
    checkOutput("issue_valid", bus.cp_input_valid, 1);
    checkOutput("issue_lhs", bus.cp_lhs, vec(1, 0, 0));
    checkOutput("issue_rhs", bus.cp_rhs, vec(0, 1, 0));
    run_until_quiet(100);
    checkOutput("single_ops", ops_completed, 1);
    check_grants('{2});

    // All four lanes at once from reset.
    do_reset();
    for (int i = 0; i < N; i++) begin
      applyStimulus(i, vec(0, 0, 1), vec(i, 0, 0), vec(0, i, 0), 1);
    end
    run_until_quiet(200);
    checkOutput("all_ops", ops_completed, 4);
    check_grants('{0, 1, 2, 3});

    // Fairness between two continuously requesting lanes.
    grant_log.delete();
    applyStimulus(0, vec(1, 0, 0), vec(0, 1, 0), vec(0, 0, 1), 3);
    applyStimulus(1, vec(0, 1, 0), vec(0, 0, 1), vec(1, 0, 0), 3);
    run_until_quiet(300);
    checkOutput("fair_ops", ops_completed, 10);
    check_grants('{0, 1, 0, 1, 0, 1});

    // Backpressure on lane 1 while lane 3 waits.
    grant_log.delete();
    bus.resp_ready[1] = 1'b0;
    exp_bp = vec(-3, 6, -3);
    applyStimulus(1, vec(2, 3, 4), vec(5, 6, 7), exp_bp, 1);
    n = 0;
    while (bus.resp_valid[1] !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checkOutput("bp_resp_seen", bus.resp_valid[1], 1);
    applyStimulus(3, vec(1, 0, 0), vec(0, 0, 1), vec(0, -1, 0), 1);
    for (int c = 0; c < 10; c++) begin
      step();
      checkOutput("bp_hold_res", bus.resp_res, exp_bp);
      checkOutput("bp_hold_id", bus.resp_id, 1);
    end
    bus.resp_ready[1] = 1'b1;
    step();
    checkOutput("bp_done", bus.resp_valid, 0);
    checkOutput("bp_ops", ops_completed, 11);
    run_until_quiet(100);
    checkOutput("bp_ops_after", ops_completed, 12);
    check_grants('{1, 3});

    // Stale unit valid must not be taken as the result.
    saw_fall = 1'b0;
    applyStimulus(2, vec(2, 3, 4), vec(5, 6, 7), vec(-3, 6, -3), 1);
    n = 0;
    while (bus.resp_valid == '0 && n < 50) begin
      step();
      if (!bus.cp_input_ready) saw_fall = 1'b1;
      n++;
    end
    checkOutput("filter_fall_seen", saw_fall, 1);
    checkOutput("filter_res", bus.resp_res, vec(-3, 6, -3));
    run_until_quiet(100);
    checkOutput("filter_ops", ops_completed, 13);

    // Reset while waiting for the unit result.
    applyStimulus(0, vec(3, 0, 0), vec(0, 2, 0), vec(0, 0, 6), 1);
    step();
    n = 0;
    while (bus.cp_input_valid !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    checkOutput("wait_reached", bus.cp_input_valid, 0);
    #2;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
    end
    applyStimulus(0, vec(0, 0, 1), vec(1, 0, 0), vec(0, 1, 0), 1);
    run_until_quiet(100);
    checkOutput("post_rst_ops", ops_completed, 1);
    check_grants('{0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
